// File: rtl/regfile_multiport.sv
// Multi-port register file: NUM_RD combinational read ports, two write ports updated on the
// falling clock edge, synchronous clear, optional write bypass and an optional hard-wired zero.
module regfile_multiport #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_EN  = 1,
    parameter int unsigned ZERO_IDX = 31,
    parameter int unsigned BYPASS   = 0
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [NUM_RD*ADDR_W-1:0]   RA,
    output logic [NUM_RD*DATA_W-1:0]   BusR,
    input  logic [ADDR_W-1:0]          RW0,
    input  logic [DATA_W-1:0]          BusW0,
    input  logic                       RegWr0,
    input  logic [ADDR_W-1:0]          RW1,
    input  logic [DATA_W-1:0]          BusW1,
    input  logic                       RegWr1
);

    localparam int unsigned Depth = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_IDX);

    logic [DATA_W-1:0] regs_q [Depth];
    logic              wr0_en;
    logic              wr1_en;

    // Writes aimed at the zero register are dropped before they reach storage or the bypass.
    assign wr0_en = RegWr0 && !((ZERO_EN != 0) && (RW0 == ZeroAddr));
    assign wr1_en = RegWr1 && !((ZERO_EN != 0) && (RW1 == ZeroAddr));

    // Port 1 is written last so it wins an address collision.
    always_ff @(negedge Clk) begin
        if (Reset) begin
            regs_q <= '{default: '0};
        end else begin
            if (wr0_en) begin
                regs_q[RW0] <= BusW0;
            end
            if (wr1_en) begin
                regs_q[RW1] <= BusW1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] rd_addr;
        logic [DATA_W-1:0] rd_data;

        assign rd_addr = RA[gi*ADDR_W +: ADDR_W];

        always_comb begin
            rd_data = regs_q[rd_addr];
            if ((BYPASS != 0) && !Reset) begin
                if (wr0_en && (RW0 == rd_addr)) begin
                    rd_data = BusW0;
                end
                if (wr1_en && (RW1 == rd_addr)) begin
                    rd_data = BusW1;
                end
            end
            if ((ZERO_EN != 0) && (rd_addr == ZeroAddr)) begin
                rd_data = '0;
            end
        end

        assign BusR[gi*DATA_W +: DATA_W] = rd_data;
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: default file, a bypassing copy sharing its inputs,
// and a narrow 4-read-port copy without a zero register.
module tb_regfile_multiport;

    logic Clk = 1'b1;
    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    // Default (BYPASS=0) and bypassing instances share every input.
    logic         Reset;
    logic [9:0]   RA;
    logic [127:0] bus_r;
    logic [127:0] bus_r_b;
    logic [4:0]   RW0, RW1;
    logic [63:0]  BusW0, BusW1;
    logic         RegWr0, RegWr1;

    logic         w_reset;
    logic [15:0]  w_ra;
    logic [127:0] w_bus_r;
    logic [3:0]   w_rw0, w_rw1;
    logic [31:0]  w_bw0, w_bw1;
    logic         w_we0, w_we1;

    regfile_multiport dut (
        .Clk(Clk), .Reset(Reset), .RA(RA), .BusR(bus_r),
        .RW0(RW0), .BusW0(BusW0), .RegWr0(RegWr0),
        .RW1(RW1), .BusW1(BusW1), .RegWr1(RegWr1)
    );

    regfile_multiport #(.BYPASS(1)) dut_b (
        .Clk(Clk), .Reset(Reset), .RA(RA), .BusR(bus_r_b),
        .RW0(RW0), .BusW0(BusW0), .RegWr0(RegWr0),
        .RW1(RW1), .BusW1(BusW1), .RegWr1(RegWr1)
    );

    regfile_multiport #(
        .DATA_W(32), .ADDR_W(4), .NUM_RD(4), .ZERO_EN(0), .ZERO_IDX(15), .BYPASS(0)
    ) dut_w (
        .Clk(Clk), .Reset(w_reset), .RA(w_ra), .BusR(w_bus_r),
        .RW0(w_rw0), .BusW0(w_bw0), .RegWr0(w_we0),
        .RW1(w_rw1), .BusW1(w_bw1), .RegWr1(w_we1)
    );

    typedef struct {
        logic        rst;
        logic        we0;
        logic [4:0]  rw0;
        logic [63:0] bw0;
        logic        we1;
        logic [4:0]  rw1;
        logic [63:0] bw1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [63:0] e0;
        logic [63:0] e1;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one cycle's inputs shortly after the rising edge; the falling edge follows.
    task automatic apply(input logic rst, input logic we0, input logic [4:0] rw0,
                         input logic [63:0] bw0, input logic we1, input logic [4:0] rw1,
                         input logic [63:0] bw1, input logic [4:0] ra0, input logic [4:0] ra1);
        @(posedge Clk);
        #1;
        Reset = rst; RegWr0 = we0; RW0 = rw0; BusW0 = bw0;
        RegWr1 = we1; RW1 = rw1; BusW1 = bw1; RA = {ra1, ra0};
    endtask

    task automatic past_edge();
        @(negedge Clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; RA = '0; RW0 = '0; RW1 = '0; BusW0 = '0; BusW1 = '0;
        RegWr0 = 1'b0; RegWr1 = 1'b0;
        w_reset = 1'b1; w_ra = '0; w_rw0 = '0; w_rw1 = '0; w_bw0 = '0; w_bw1 = '0;
        w_we0 = 1'b0; w_we1 = 1'b0;

        // Reset clears everything.
        apply(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd3, 5'd7);
        past_edge();
        check("reset_ra3", bus_r[63:0], 64'd0);
        check("reset_ra7", bus_r[127:64], 64'd0);
        apply(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
        for (int k = 0; k < 32; k++) begin
            RA = {5'(31 - k), 5'(k)};
            #1;
            check($sformatf("reset_all_p0_r%0d", k), bus_r[63:0], 64'd0);
            check($sformatf("reset_all_p1_r%0d", 31 - k), bus_r[127:64], 64'd0);
        end

        for (int k = 0; k < 31; k++) begin
            apply(1'b0, 1'b1, 5'(k), 64'(k), 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
        end
        // Writes to the zero register are invisible, even through the bypass.
        apply(1'b0, 1'b1, 5'd31, 64'h12345678, 1'b0, 5'd0, 64'd0, 5'd31, 5'd30);
        #1;
        check("xzr_pre", bus_r[63:0], 64'd0);
        check("xzr_pre_bypass", bus_r_b[63:0], 64'd0);
        past_edge();
        check("xzr_post", bus_r[63:0], 64'd0);
        check("r30_post", bus_r[127:64], 64'd30);
        apply(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
        for (int k = 0; k < 32; k++) begin
            RA = {5'(31 - k), 5'(k)};
            #1;
            check($sformatf("fill_p0_r%0d", k), bus_r[63:0], (k == 31) ? 64'd0 : 64'(k));
            check($sformatf("fill_p1_r%0d", 31 - k), bus_r[127:64],
                  (k == 0) ? 64'd0 : 64'(31 - k));
        end

        // Old value vs bypass before the edge; both agree afterwards.
        apply(1'b0, 1'b1, 5'd13, 64'hABCD, 1'b0, 5'd0, 64'd0, 5'd13, 5'd12);
        #1;
        check("nobyp_pre", bus_r[63:0], 64'd13);
        check("byp_pre", bus_r_b[63:0], 64'hABCD);
        check("byp_other_port", bus_r_b[127:64], 64'd12);
        past_edge();
        check("nobyp_post", bus_r[63:0], 64'hABCD);
        check("byp_post", bus_r_b[63:0], 64'hABCD);

        // Both write ports hit the read address: port 1 data forwarded.
        apply(1'b0, 1'b1, 5'd20, 64'h1111, 1'b1, 5'd20, 64'h2222, 5'd20, 5'd31);
        #1;
        check("byp_prio_pre", bus_r_b[63:0], 64'h2222);
        check("nobyp_prio_pre", bus_r[63:0], 64'd20);
        past_edge();
        check("prio_post", bus_r[63:0], 64'h2222);

        // Reset suppresses the bypass and overrides the write.
        apply(1'b1, 1'b1, 5'd7, 64'hBEEF, 1'b0, 5'd0, 64'd0, 5'd7, 5'd20);
        #1;
        check("rst_byp_pre", bus_r_b[63:0], 64'd7);
        past_edge();
        check("rst_byp_post", bus_r_b[63:0], 64'd0);
        check("rst_clear_r20", bus_r[127:64], 64'd0);

        vecs[0] = '{1'b0, 1'b1, 5'd10, 64'hAAAA, 1'b1, 5'd10, 64'h5555, 5'd10, 5'd10,
                    64'h5555, 64'h5555};
        vecs[1] = '{1'b0, 1'b1, 5'd1, 64'd100, 1'b1, 5'd2, 64'd200, 5'd1, 5'd2,
                    64'd100, 64'd200};
        vecs[2] = '{1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd31, 64'hFFFF, 5'd31, 5'd10,
                    64'd0, 64'h5555};
        vecs[3] = '{1'b0, 1'b1, 5'd0, 64'h0123456789ABCDEF, 1'b0, 5'd0, 64'd0, 5'd0, 5'd1,
                    64'h0123456789ABCDEF, 64'd100};
        vecs[4] = '{1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd2, 5'd0,
                    64'd200, 64'h0123456789ABCDEF};
        vecs[5] = '{1'b1, 1'b1, 5'd14, 64'h9080009, 1'b0, 5'd0, 64'd0, 5'd14, 5'd10,
                    64'd0, 64'd0};
        vecs[6] = '{1'b0, 1'b1, 5'd14, 64'd77, 1'b0, 5'd0, 64'd0, 5'd14, 5'd1,
                    64'd77, 64'd0};
        for (int i = 0; i < 7; i++) begin
            apply(vecs[i].rst, vecs[i].we0, vecs[i].rw0, vecs[i].bw0, vecs[i].we1,
                  vecs[i].rw1, vecs[i].bw1, vecs[i].ra0, vecs[i].ra1);
            past_edge();
            check($sformatf("vec%0d_p0", i), bus_r[63:0], vecs[i].e0);
            check($sformatf("vec%0d_p1", i), bus_r[127:64], vecs[i].e1);
        end

        // Narrow 4-port instance, zero register disabled.
        @(posedge Clk); #1;
        w_reset = 1'b1;
        past_edge();
        for (int i = 0; i < 8; i++) begin
            @(posedge Clk); #1;
            w_reset = 1'b0;
            w_we0 = 1'b1; w_rw0 = 4'(i);     w_bw0 = 32'(i * 3);
            w_we1 = 1'b1; w_rw1 = 4'(i + 8); w_bw1 = 32'((i + 8) * 3);
            past_edge();
        end
        w_we0 = 1'b0; w_we1 = 1'b0;
        w_ra = {4'd2, 4'd5, 4'd9, 4'd15};
        #1;
        check("w_port0_r15", 64'(w_bus_r[31:0]), 64'd45);
        check("w_port1_r9", 64'(w_bus_r[63:32]), 64'd27);
        check("w_port2_r5", 64'(w_bus_r[95:64]), 64'd15);
        check("w_port3_r2", 64'(w_bus_r[127:96]), 64'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
